alu_ctrl_mdu: RTL and testbench
===============================

Name: alu_ctrl_mdu

Overview:
ALU control decoder with an integrated iterative multiply/divide unit (MDU), parametrised in datapath width.
- Decodes ALUOp_i/funct_i into the 4-bit ALUCtrl_o for the combinational ALU.
- Runs mult/multu/div/divu over multiple cycles and holds results in HI/LO registers.
- Raises a stall to the pipeline when an instruction needs the busy MDU.
- Sits in the decode/execute stage beside the ALU.

Parameters:
WIDTH, 32, operand and HI/LO width (>= 4)
ENABLE_DIV, 1, 0 = div/divu decode as MDU no-op and never start the engine

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
valid_i  in  1  instruction in execute stage is valid
ALUOp_i  in  6  instruction opcode field
funct_i  in  6  R-type funct field
src1_i  in  WIDTH  rs operand (multiplicand/dividend)
src2_i  in  WIDTH  rt operand (multiplier/divisor)
ALUCtrl_o  out  4  ALU operation select
stall_o  out  1  freeze the pipeline this cycle
busy_o  out  1  MDU engine running
done_o  out  1  one-cycle pulse; new HI/LO visible this cycle
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- ALUCtrl_o is combinational and independent of valid_i:
  - 0000 and; 0001 or, R-type 100101
  - 0010 add, addi, lw, sw
  - 0110 sub, beq, bne, bge, bgt
  - 0111 slt, slti
  - 1010 MDU op, no ALU writeback: mult 011000, multu 011001, div 011010, divu 011011
  - 1100 pass MDU result: mfhi 010000 → hi_o, mflo 010010 → lo_o
  - 1111 anything else
- Start condition: valid_i & MDU op & state==IDLE & !stall_o. The cycle this holds is cycle 0.
- In cycle 0 the block latches operands, signedness and op. Signed ops convert operands to magnitudes.
- FSM states:
  - IDLE → RUN on start. IDLE → FIX on divide with src2_i==0.
  - RUN: a counter loads WIDTH-1 and decrements once per cycle. Each cycle does one radix-2 step: shift-add for multiply, restoring subtract for divide. RUN → FIX when the counter reaches 0, i.e. after WIDTH RUN cycles (cycles 1..WIDTH).
  - FIX, one cycle: applies sign correction. Product is negated if operand signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign. HI/LO load at the end of FIX. FIX → IDLE.
- done_o is registered and high in cycle WIDTH+2, the first cycle new hi_o/lo_o are visible. For divide-by-zero, done_o is high in cycle 2.
- busy_o = (state != IDLE).
- stall_o is combinational: valid_i & busy_o & (MDU op | mfhi | mflo). Other instructions never stall.
- Multiply results: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
- Divide results: LO = quotient, HI = remainder.
- Divide-by-zero: LO = all ones, HI = dividend. No RUN phase.
- Signed INT_MIN / -1: LO = INT_MIN, HI = 0. Falls out naturally from magnitude arithmetic.
- ENABLE_DIV=0: div/divu still give ALUCtrl_o=1010 but never start. HI/LO unchanged.
- HI/LO change only at the end of FIX.
- Reset, including mid-operation:
  - state IDLE, counter 0, hi_o=lo_o=0
  - done_o=0, busy_o=0, stall_o=0
  - the in-flight operation is discarded

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode and funct constants
  - ALUCtrl encodings
  - FSM state enum {IDLE, RUN, FIX}
- Sub-module mdu_iter holds the datapath: operand/accumulator registers, single-step shift-add / restoring-subtract, and FIX sign correction. alu_ctrl_mdu keeps the decode, FSM, counter, stall and HI/LO.

Test Plan:
- Decode sweep of every listed ALUOp_i/funct_i pair plus one unlisted opcode → ALUCtrl_o matches the table; unlisted gives 1111; stall_o=0 while idle.
- mult src1=7, src2=0xFFFFFFFD (WIDTH=32) → busy_o cycles 1..33; done_o at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- divu 100/7 → lo=14, hi=2. div 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- div 5/0 → done_o at cycle 2; lo=0xFFFFFFFF, hi=5; no RUN cycles.
- mfhi issued at cycle 3 of a mult → stall_o high cycles 3..33; low at 34, where hi_o is the new product. An add at cycle 3 → stall_o=0.
- rst_i low at cycle 10 of a mult → immediately busy_o=0, hi=lo=0; after release, new mult 3*4 → lo=12, hi=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control decoder and the iterative
// multiply/divide unit: opcode/funct encodings, ALU select codes, FSM states.
package alu_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGE   = 6'b000001;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // R-type funct codes
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // ALU operation select encodings
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MDU  = 4'b1010;
    localparam logic [3:0] ALU_MF   = 4'b1100;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    // MDU sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // MDU operation, equal to funct[1:0] of the mult/multu/div/divu group
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    // Opcode/funct to ALU select; unknown encodings map to ALU_NONE
    function automatic logic [3:0] decode_alu_ctrl(input logic [5:0] op,
                                                   input logic [5:0] funct);
        logic [3:0] ctrl;
        ctrl = ALU_NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_AND:                          ctrl = ALU_AND;
                    F_OR:                           ctrl = ALU_OR;
                    F_ADD:                          ctrl = ALU_ADD;
                    F_SUB:                          ctrl = ALU_SUB;
                    F_SLT:                          ctrl = ALU_SLT;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl = ALU_MDU;
                    F_MFHI, F_MFLO:                 ctrl = ALU_MF;
                    default:                        ctrl = ALU_NONE;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW:           ctrl = ALU_ADD;
            OP_BEQ, OP_BNE, OP_BGE, OP_BGT:  ctrl = ALU_SUB;
            OP_SLTI:                         ctrl = ALU_SLT;
            default:                         ctrl = ALU_NONE;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath. Operands are latched as magnitudes on
// load, one radix-2 step (shift-add or restoring subtract) runs per step
// cycle, and the sign-corrected HI/LO result is presented combinationally.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    mdu_op_e            op;
    logic               signed_op;
    logic               is_div;
    logic               s1_neg;
    logic               s2_neg;
    logic               div0;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;

    // acc holds {product} for multiply, {remainder, quotient} for divide
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;

    assign op        = mdu_op_e'(op_i);
    assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    assign is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign s1_neg    = signed_op & src1_i[WIDTH-1];
    assign s2_neg    = signed_op & src2_i[WIDTH-1];
    assign mag1      = s1_neg ? ('0 - src1_i) : src1_i;
    assign mag2      = s2_neg ? ('0 - src2_i) : src2_i;
    assign div0      = is_div & (src2_i == '0);

    // One radix-2 iteration of the selected operation
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        acc_step  = acc_q;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        if (is_div_q) begin
            if (div_trial[WIDTH])
                acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
            else
                acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Operand latch on load, accumulator update on each step
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale partial result.
        if (!rst_i) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (load_i) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            if (div0)
                acc_q <= {src1_i, {WIDTH{1'b1}}};
            else
                acc_q <= {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
            opnd_q    <= is_div ? mag2 : mag1;
            is_div_q  <= is_div;
            neg_res_q <= !div0 && (s1_neg ^ s2_neg);
            neg_rem_q <= !div0 && is_div && s1_neg;
        end else if (step_i) begin
            acc_q <= acc_step;
        end
    end

    // Sign correction; divide-by-zero has both flags clear and passes through
    always_comb begin
        prod_neg = '0 - acc_q;
        res_hi_o = acc_q[2*WIDTH-1:WIDTH];
        res_lo_o = acc_q[WIDTH-1:0];
        if (!is_div_q) begin
            if (neg_res_q) begin
                res_hi_o = prod_neg[2*WIDTH-1:WIDTH];
                res_lo_o = prod_neg[WIDTH-1:0];
            end
        end else begin
            if (neg_res_q) res_lo_o = '0 - acc_q[WIDTH-1:0];
            if (neg_rem_q) res_hi_o = '0 - acc_q[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an iterative multiply/divide unit. Keeps the
// decode, the IDLE/RUN/FIX sequencer, the step counter, pipeline stall and
// the architectural HI/LO registers; the arithmetic lives in mdu_iter.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_DIV = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [5:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [3:0]       ALUCtrl_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             is_mdu;
    logic             is_mf;
    logic             mdu_runs;
    logic             start;
    logic             div0_start;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign ALUCtrl_o  = decode_alu_ctrl(ALUOp_i, funct_i);
    assign is_mdu     = (ALUOp_i == OP_RTYPE) && (funct_i[5:2] == 4'b0110);
    assign is_mf      = (ALUOp_i == OP_RTYPE) && ((funct_i == F_MFHI) || (funct_i == F_MFLO));
    // With divide disabled, div/divu still decode as MDU ops but never launch
    assign mdu_runs   = is_mdu && (ENABLE_DIV || !funct_i[1]);
    assign busy_o     = (state_q != IDLE);
    assign stall_o    = valid_i & busy_o & (is_mdu | is_mf);
    assign start      = valid_i & mdu_runs & (state_q == IDLE) & ~stall_o;
    assign div0_start = funct_i[1] & (src2_i == '0);
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (start),
        .op_i     (funct_i[1:0]),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .step_i   (state_q == RUN),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo)
    );

    // Sequencer next state: divide-by-zero skips straight to FIX
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = div0_start ? FIX : RUN;
            RUN:     if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, step counter, done pulse and HI/LO registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIX);
            if (start && !div0_start)
                cnt_q <= CW'(WIDTH - 1);
            else if ((state_q == RUN) && (cnt_q != '0))
                cnt_q <= cnt_q - CW'(1);
            if (state_q == FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: decode sweep, directed and random
// multiply/divide against a 64-bit arithmetic reference, stall timing,
// divide-by-zero, mid-operation reset and a divide-disabled 8-bit instance.
module tb_alu_ctrl_mdu;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        valid_nd;
    logic [5:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  alu_ctrl, alu_ctrl_nd;
    logic        stall, busy, done;
    logic        stall_nd, busy_nd, done_nd;
    logic [31:0] hi, lo;
    logic [7:0]  hi_nd, lo_nd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_ctrl_mdu #(.WIDTH(32), .ENABLE_DIV(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ALUOp_i(alu_op), .funct_i(funct),
        .src1_i(src1), .src2_i(src2), .ALUCtrl_o(alu_ctrl), .stall_o(stall),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    alu_ctrl_mdu #(.WIDTH(8), .ENABLE_DIV(1'b0)) u_nodiv (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_nd), .ALUOp_i(alu_op), .funct_i(funct),
        .src1_i(src1[7:0]), .src2_i(src2[7:0]), .ALUCtrl_o(alu_ctrl_nd), .stall_o(stall_nd),
        .busy_o(busy_nd), .done_o(done_nd), .hi_o(hi_nd), .lo_o(lo_nd)
    );

    // Reference: plain 64-bit arithmetic, SV '/' and '%' truncate toward zero
    function automatic void ref_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rhi, output logic [31:0] rlo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rhi = '0;
        rlo = '0;
        if (f == F_MULT) begin
            p = 64'(sa * sb);
            rhi = p[63:32]; rlo = p[31:0];
        end else if (f == F_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            rhi = p[63:32]; rlo = p[31:0];
        end else if (b == 32'b0) begin
            rhi = a; rlo = 32'hFFFF_FFFF;
        end else if (f == F_DIV) begin
            q = sa / sb; r = sa % sb;
            rlo = q[31:0]; rhi = r[31:0];
        end else begin
            rlo = a / b; rhi = a % b;
        end
    endfunction

    // Issue one MDU op in the current cycle (called at a negedge) and wait for done
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bc,
                          output logic [31:0] ohi, output logic [31:0] olo);
        valid = 1'b1; alu_op = OP_RTYPE; funct = f; src1 = a; src2 = b;
        @(negedge clk);
        valid = 1'b0; funct = F_ADD;
        lat = 1; bc = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        ohi = hi; olo = lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; valid_nd = 1'b1; alu_op = OP_RTYPE; funct = F_MULT;
        src1 = 32'd9; src2 = 32'd9;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
        n_cmp++; if (busy_nd !== 1'b0 || hi_nd !== 8'h0 || lo_nd !== 8'h0) begin n_bad++; $display("FAIL reset_nd got busy=%b hi=%h lo=%h want 0", busy_nd, hi_nd, lo_nd); end
        valid = 1'b0; valid_nd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed { logic [5:0] op; logic [5:0] fn; logic [3:0] ctrl; } dec_t;
    dec_t dec_tbl [0:21] = '{
        '{OP_RTYPE, F_AND, 4'b0000}, '{OP_RTYPE, F_OR, 4'b0001}, '{OP_RTYPE, F_ADD, 4'b0010},
        '{OP_ADDI, 6'h00, 4'b0010},  '{OP_LW, 6'h15, 4'b0010},   '{OP_SW, F_MULT, 4'b0010},
        '{OP_RTYPE, F_SUB, 4'b0110}, '{OP_BEQ, 6'h00, 4'b0110},  '{OP_BNE, 6'h3F, 4'b0110},
        '{OP_BGE, 6'h00, 4'b0110},   '{OP_BGT, 6'h00, 4'b0110},  '{OP_RTYPE, F_SLT, 4'b0111},
        '{OP_SLTI, 6'h00, 4'b0111},  '{OP_RTYPE, F_MULT, 4'b1010}, '{OP_RTYPE, F_MULTU, 4'b1010},
        '{OP_RTYPE, F_DIV, 4'b1010}, '{OP_RTYPE, F_DIVU, 4'b1010}, '{OP_RTYPE, F_MFHI, 4'b1100},
        '{OP_RTYPE, F_MFLO, 4'b1100}, '{6'b111111, 6'h00, 4'b1111}, '{OP_RTYPE, 6'h00, 4'b1111},
        '{OP_RTYPE, 6'b011100, 4'b1111}
    };

    task automatic test_decode();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            alu_op = dec_tbl[i].op; funct = dec_tbl[i].fn; valid = 1'b1;
            #1;
            n_cmp++; if (alu_ctrl !== dec_tbl[i].ctrl || stall !== 1'b0) begin n_bad++; $display("FAIL decode[%0d] got ctrl=%b stall=%b want ctrl=%b stall=0", i, alu_ctrl, stall, dec_tbl[i].ctrl); end
            valid = 1'b0;
            #1;
            n_cmp++; if (alu_ctrl !== dec_tbl[i].ctrl) begin n_bad++; $display("FAIL decode_novalid[%0d] got %b want %b", i, alu_ctrl, dec_tbl[i].ctrl); end
        end
        alu_op = OP_RTYPE; funct = F_ADD;
    endtask

    typedef struct packed { logic [5:0] fn; logic [31:0] a, b, ehi, elo; } dir_t;
    dir_t dir_tbl [0:3] = '{
        '{F_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
        '{F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14},
        '{F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
        '{F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000}
    };

    task automatic test_directed();
        int lat, bc;
        logic [31:0] ohi, olo;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_op(dir_tbl[i].fn, dir_tbl[i].a, dir_tbl[i].b, lat, bc, ohi, olo);
            n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL dir[%0d]_done_cycle got %0d want 34", i, lat); end
            n_cmp++; if (bc !== 33) begin n_bad++; $display("FAIL dir[%0d]_busy_cycles got %0d want 33", i, bc); end
            n_cmp++; if (ohi !== dir_tbl[i].ehi) begin n_bad++; $display("FAIL dir[%0d]_hi got %h want %h", i, ohi, dir_tbl[i].ehi); end
            n_cmp++; if (olo !== dir_tbl[i].elo) begin n_bad++; $display("FAIL dir[%0d]_lo got %h want %h", i, olo, dir_tbl[i].elo); end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        logic [31:0] ohi, olo;
        @(negedge clk);
        run_op(F_DIV, 32'd5, 32'd0, lat, bc, ohi, olo);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL div0_done_cycle got %0d want 2", lat); end
        n_cmp++; if (bc !== 1) begin n_bad++; $display("FAIL div0_busy_cycles got %0d want 1", bc); end
        n_cmp++; if (olo !== 32'hFFFF_FFFF || ohi !== 32'd5) begin n_bad++; $display("FAIL div0_result got %h/%h want 00000005/ffffffff", ohi, olo); end
        // Non-starting instructions must leave HI/LO alone
        valid = 1'b1; funct = F_MFLO;
        #1;
        n_cmp++; if (alu_ctrl !== 4'b1100 || stall !== 1'b0) begin n_bad++; $display("FAIL mflo_idle got ctrl=%b stall=%b want 1100/0", alu_ctrl, stall); end
        repeat (3) @(negedge clk);
        valid = 1'b0; funct = F_ADD;
        n_cmp++; if (busy !== 1'b0 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL hilo_hold got busy=%b %h/%h want 0 00000005/ffffffff", busy, hi, lo); end
    endtask

    task automatic test_stall();
        logic [31:0] ehi, elo;
        int cyc, scnt;
        ref_mdu(F_MULT, 32'h1234_5678, 32'h9ABC_DEF0, ehi, elo);
        @(negedge clk);
        valid = 1'b1; alu_op = OP_RTYPE; funct = F_MULT; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
        @(negedge clk);
        valid = 1'b0; funct = F_ADD;
        repeat (2) @(negedge clk);
        valid = 1'b1; funct = F_ADD;
        #1;
        n_cmp++; if (stall !== 1'b0 || alu_ctrl !== 4'b0010) begin n_bad++; $display("FAIL add_while_busy got stall=%b ctrl=%b want 0/0010", stall, alu_ctrl); end
        funct = F_MFHI;
        #1;
        cyc = 3; scnt = 0;
        while (stall && cyc < 100) begin
            scnt++;
            @(negedge clk);
            #1;
            cyc++;
        end
        n_cmp++; if (scnt !== 31 || cyc !== 34) begin n_bad++; $display("FAIL mfhi_stall got %0d cycles, released at %0d want 31 cycles, released at 34", scnt, cyc); end
        n_cmp++; if (hi !== ehi || done !== 1'b1) begin n_bad++; $display("FAIL mfhi_release got hi=%h done=%b want hi=%h done=1", hi, done, ehi); end
        valid = 1'b0; funct = F_ADD;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [31:0] ohi, olo, ehi, elo, a, b;
        logic [5:0] f;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            f = 6'(F_MULT + $urandom_range(0, 3));
            a = $urandom; b = $urandom;
            ref_mdu(f, a, b, ehi, elo);
            run_op(f, a, b, lat, bc, ohi, olo);
            n_cmp++; if (lat !== 34 || ohi !== ehi || olo !== elo) begin n_bad++; $display("FAIL b2b[%0d] f=%b a=%h b=%h got lat=%0d %h/%h want 34 %h/%h", i, f, a, b, lat, ohi, olo, ehi, elo); end
        end
    endtask

    task automatic test_random();
        int lat, bc, elat, mode;
        logic [31:0] ohi, olo, ehi, elo, a, b;
        logic [5:0] f;
        for (int i = 0; i < 40; i++) begin
            f = 6'(F_MULT + $urandom_range(0, 3));
            mode = $urandom_range(0, 7);
            a = $urandom; b = $urandom;
            if (mode == 0) b = 32'h0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) begin a = 32'($signed(8'($urandom))); b = 32'($signed(4'($urandom))); end
            ref_mdu(f, a, b, ehi, elo);
            elat = (f[1] && b == 32'h0) ? 2 : 34;
            @(negedge clk);
            run_op(f, a, b, lat, bc, ohi, olo);
            n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL rand[%0d]_latency f=%b got %0d want %0d", i, f, lat, elat); end
            n_cmp++; if (ohi !== ehi || olo !== elo) begin n_bad++; $display("FAIL rand[%0d] f=%b a=%h b=%h got %h/%h want %h/%h", i, f, a, b, ohi, olo, ehi, elo); end
        end
    endtask

    task automatic test_nodiv();
        int lat, act;
        @(negedge clk);
        valid_nd = 1'b1; alu_op = OP_RTYPE; funct = F_MULT; src1 = 32'h0000_00FB; src2 = 32'd3;
        @(negedge clk);
        valid_nd = 1'b0; funct = F_ADD;
        lat = 1;
        while (!done_nd && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL nd_mult_done_cycle got %0d want 10", lat); end
        n_cmp++; if (hi_nd !== 8'hFF || lo_nd !== 8'hF1) begin n_bad++; $display("FAIL nd_mult got %h/%h want ff/f1", hi_nd, lo_nd); end
        valid_nd = 1'b1; funct = F_DIV; src2 = 32'd2;
        #1;
        n_cmp++; if (alu_ctrl_nd !== 4'b1010 || stall_nd !== 1'b0) begin n_bad++; $display("FAIL nd_div_decode got ctrl=%b stall=%b want 1010/0", alu_ctrl_nd, stall_nd); end
        @(negedge clk);
        valid_nd = 1'b0; funct = F_ADD;
        act = 0;
        repeat (12) begin
            #1;
            if (busy_nd || done_nd) act++;
            @(negedge clk);
        end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL nd_div_started got %0d active cycles want 0", act); end
        n_cmp++; if (hi_nd !== 8'hFF || lo_nd !== 8'hF1) begin n_bad++; $display("FAIL nd_div_hilo got %h/%h want ff/f1", hi_nd, lo_nd); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        logic [31:0] ohi, olo;
        @(negedge clk);
        valid = 1'b1; alu_op = OP_RTYPE; funct = F_MULT; src1 = 32'h0001_2345; src2 = 32'h0006_789A;
        @(negedge clk);
        valid = 1'b0; funct = F_ADD;
        repeat (9) @(negedge clk);
        rst_n = 1'b0; valid = 1'b1; funct = F_MULT;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL midreset_ctrl got busy=%b done=%b stall=%b want 0/0/0", busy, done, stall); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL midreset_hilo got %h/%h want 0/0", hi, lo); end
        valid = 1'b0; funct = F_ADD;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(F_MULT, 32'd3, 32'd4, lat, bc, ohi, olo);
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL postreset_done_cycle got %0d want 34", lat); end
        n_cmp++; if (ohi !== 32'h0 || olo !== 32'd12) begin n_bad++; $display("FAIL postreset_mult got %h/%h want 00000000/0000000c", ohi, olo); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_directed();
        test_div_zero();
        test_stall();
        test_back_to_back();
        test_random();
        test_nodiv();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not finish in time");
        $fatal(1);
    end

endmodule
